// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: transmitter side of the PE operand interface.
// Accepts one operand vector per beat and skews it diagonally, so lane i lags lane 0 by i
// cycles. DONE pulses once the last element has left the highest lane.
// Optional feature macro: FEEDER_STALL_CNT_EN adds a saturating 32-bit STALL_CNT output.
module systolic_edge_feeder #(
  parameter int unsigned OPND_BWIDTH = 8,
  parameter int unsigned N_LANES     = 4,
  parameter int unsigned K_MAX       = 16
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             STALL,
  input  logic                             START,
  input  logic                             IN_VALID,
  output logic                             IN_READY,
  input  logic [N_LANES*OPND_BWIDTH-1:0]   IN_DATA,
  input  logic                             IN_LAST,
  output logic [N_LANES*OPND_BWIDTH-1:0]   OPND_out,
  output logic [N_LANES-1:0]               OPND_is_valid_out,
  output logic                             BUSY,
  output logic                             DONE,
  output logic                             OVERFLOW
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]                      STALL_CNT
`endif
);

  localparam int unsigned CntW = $clog2(K_MAX + 1);
  localparam int unsigned DrnW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_beat_cnt, w_beat_cnt_d;
  logic [DrnW-1:0] r_drn_cnt, w_drn_cnt_d;
  logic            r_ovf, w_ovf_d;
  logic            r_done, w_done_d;
  logic            w_accept;
  logic            w_start_ok;

  // START is ignored while DONE is still showing, even though the state is already idle.
  assign w_start_ok = (r_state == StIdle) & START & ~STALL & ~r_done;
  assign IN_READY   = (r_state == StStream) & ~STALL;
  assign w_accept   = IN_READY & IN_VALID;
  assign BUSY       = (r_state != StIdle);
  assign DONE       = r_done;
  assign OVERFLOW   = r_ovf;

  // Next-state logic; a stalled cycle holds every register, including the DONE pulse.
  always_comb begin
    w_state_d    = r_state;
    w_beat_cnt_d = r_beat_cnt;
    w_drn_cnt_d  = r_drn_cnt;
    w_ovf_d      = r_ovf;
    w_done_d     = r_done;
    if (!STALL) begin
      w_done_d = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start_ok) begin
            w_state_d    = StStream;
            w_beat_cnt_d = '0;
            w_ovf_d      = 1'b0;
          end
        end
        StStream: begin
          if (w_accept) begin
            w_beat_cnt_d = r_beat_cnt + CntW'(1);
            if (IN_LAST || (r_beat_cnt == CntW'(K_MAX - 1))) begin
              if (!IN_LAST) w_ovf_d = 1'b1;
              if (N_LANES == 1) begin
                // Single lane: the accept edge is also the edge the last element lands.
                w_state_d = StIdle;
                w_done_d  = 1'b1;
              end else begin
                w_state_d   = StDrain;
                w_drn_cnt_d = '0;
              end
            end
          end
        end
        StDrain: begin
          if (r_drn_cnt == DrnW'(N_LANES - 2)) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end else begin
            w_drn_cnt_d = r_drn_cnt + DrnW'(1);
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= StIdle;
      r_beat_cnt <= '0;
      r_drn_cnt  <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_beat_cnt <= w_beat_cnt_d;
      r_drn_cnt  <= w_drn_cnt_d;
      r_ovf      <= w_ovf_d;
      r_done     <= w_done_d;
    end
  end

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    logic [OPND_BWIDTH-1:0] r_data [gi+1];
    logic [gi:0]            r_vld;

    // Skew chain of gi+1 stages; the head takes the accepted element or a zero bubble.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        for (int j = 0; j <= gi; j++) r_data[j] <= '0;
        r_vld <= '0;
      end else if (!STALL) begin
        r_data[0] <= w_accept ? IN_DATA[gi*OPND_BWIDTH +: OPND_BWIDTH] : '0;
        r_vld[0]  <= w_accept;
        for (int j = 1; j <= gi; j++) begin
          r_data[j] <= r_data[j-1];
          r_vld[j]  <= r_vld[j-1];
        end
      end
    end

    assign OPND_out[gi*OPND_BWIDTH +: OPND_BWIDTH] = r_data[gi];
    assign OPND_is_valid_out[gi]                   = r_vld[gi];
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Counts stalled cycles while a stream is in flight; saturates instead of wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (STALL && BUSY && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Self-checking bench for systolic_edge_feeder (N_LANES=4, OPND_BWIDTH=8, K_MAX=16).
// Reference model: a history of what entered the lane heads, indexed by non-stalled edge;
// lane i shows the entry from i edges earlier. Honours FEEDER_STALL_CNT_EN when defined.
module tb_systolic_edge_feeder;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int K  = 16;
  localparam int DW = N * W;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          STALL = 1'b0;
  logic          START = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_LAST = 1'b0;
  logic [DW-1:0] IN_DATA = '0;
  logic          IN_READY;
  logic [DW-1:0] OPND_out;
  logic [N-1:0]  OPND_is_valid_out;
  logic          BUSY, DONE, OVERFLOW;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0]   STALL_CNT;
`endif

  systolic_edge_feeder #(.OPND_BWIDTH(W), .N_LANES(N), .K_MAX(K)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .START(START),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
    .OPND_out(OPND_out), .OPND_is_valid_out(OPND_is_valid_out),
    .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW)
`ifdef FEEDER_STALL_CNT_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model state
  int            n_edges;
  bit            hist_v[$];
  logic [DW-1:0] hist_d[$];
  bit            m_busy, m_streaming, m_ovf;
  int            m_beats, m_done_edge;
  logic [31:0]   m_sc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_edges = 0; hist_v.delete(); hist_d.delete();
    m_busy = 0; m_streaming = 0; m_ovf = 0; m_beats = 0; m_done_edge = -1; m_sc = '0;
  endtask

  task automatic model_edge(input bit stall, input bit start, input bit vld, input bit last,
                            input logic [DW-1:0] data);
    bit acc, done_now;
    if (stall) begin
      if (m_busy && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      return;
    end
    acc      = m_streaming && vld;
    done_now = (m_done_edge == n_edges);
    n_edges++;
    hist_v.push_back(acc);
    hist_d.push_back(acc ? data : '0);
    if (acc) begin
      m_beats++;
      if (last || m_beats == K) begin
        if (!last) m_ovf = 1;
        m_streaming = 0;
        m_done_edge = n_edges + N - 1;
      end
    end else if (!m_busy && start && !done_now) begin
      m_busy = 1; m_streaming = 1; m_beats = 0; m_ovf = 0; m_sc = '0;
    end
    if (m_done_edge == n_edges) m_busy = 0;
  endtask

  task automatic check_model();
    logic [N-1:0]  ev;
    logic [DW-1:0] ed, tmp;
    int idx;
    ev = '0; ed = '0;
    for (int i = 0; i < N; i++) begin
      idx = n_edges - i - 1;
      if (idx >= 0) begin
        ev[i] = hist_v[idx];
        tmp   = hist_d[idx];
        ed[i*W +: W] = tmp[i*W +: W];
      end
    end
    chk("lane_valid", OPND_is_valid_out, ev);
    chk("lane_data", OPND_out, ed);
    chk("busy", BUSY, m_busy);
    chk("done", DONE, m_done_edge == n_edges);
    chk("overflow", OVERFLOW, m_ovf);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cnt", STALL_CNT, m_sc);
`endif
  endtask

  task automatic step(input bit stall, input bit start, input bit vld, input bit last,
                      input logic [DW-1:0] data, output bit rdy);
    STALL = stall; START = start; IN_VALID = vld; IN_LAST = last; IN_DATA = data;
    #1;
    rdy = IN_READY;
    chk("in_ready", IN_READY, !stall && m_streaming);
    @(posedge CLK);
    model_edge(stall, start, vld, last, data);
    #1;
    check_model();
  endtask

  // Idle, START, nbeats beats (optional gap / stall after the first), then wait for DONE.
  task automatic run_stream(input int nbeats, input int gap, input int stalls,
                            input bit use_last, output int lat);
    bit r;
    int c0;
    step(0, 0, 0, 0, '0, r);
    step(0, 1, 0, 0, '0, r);
    c0 = cyc;
    for (int b = 0; b < nbeats; b++) begin
      step(0, 0, 1, use_last && (b == nbeats - 1), DW'($urandom), r);
      if (b == 0) begin
        repeat (gap) step(0, 0, 0, 0, '0, r);
        repeat (stalls) step(1, 0, 1, 0, DW'($urandom), r);
      end
    end
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (DONE === 1'b1) lat = cyc - c0;
      else step(0, 0, 0, 0, '0, r);
    end
  endtask

  typedef struct {
    bit            stall, start, vld, last;
    logic [DW-1:0] data;
    bit            exp_ready;
    logic [N-1:0]  exp_vld;
    logic [DW-1:0] exp_opnd;
    bit            exp_busy, exp_done;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit r;
    int lat, c0;

    // Basic skew, then START during the DONE cycle (row 6) must be ignored.
    tbl[0] = '{0, 1, 0, 0, 32'h0,        0, 4'b0000, 32'h0000_0000, 1, 0};
    tbl[1] = '{0, 0, 1, 0, 32'h0403_0201, 1, 4'b0001, 32'h0000_0001, 1, 0};
    tbl[2] = '{0, 0, 1, 1, 32'h0807_0605, 1, 4'b0011, 32'h0000_0205, 1, 0};
    tbl[3] = '{0, 0, 0, 0, 32'h0,        0, 4'b0110, 32'h0003_0600, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 32'h0,        0, 4'b1100, 32'h0407_0000, 1, 0};
    tbl[5] = '{0, 0, 0, 0, 32'h0,        0, 4'b1000, 32'h0800_0000, 0, 1};
    tbl[6] = '{0, 1, 0, 0, 32'h0,        0, 4'b0000, 32'h0000_0000, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 32'h0,        0, 4'b0000, 32'h0000_0000, 0, 0};

    #1 RST = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("rst_ready", IN_READY, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].stall, tbl[i].start, tbl[i].vld, tbl[i].last, tbl[i].data, r);
      chk("tbl_ready", r, tbl[i].exp_ready);
      chk("tbl_valid", OPND_is_valid_out, tbl[i].exp_vld);
      chk("tbl_opnd", OPND_out, tbl[i].exp_opnd);
      chk("tbl_busy", BUSY, tbl[i].exp_busy);
      chk("tbl_done", DONE, tbl[i].exp_done);
    end

    run_stream(2, 0, 0, 1, lat);
    chk("lat_basic", lat, 5);
    run_stream(2, 1, 0, 1, lat);
    chk("lat_bubble", lat, 6);
    run_stream(2, 0, 3, 1, lat);
    chk("lat_stall", lat, 8);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cnt_3", STALL_CNT, 3);
`endif

    // Overflow: 17 beats without LAST; the 17th must never be taken.
    run_stream(17, 0, 0, 0, lat);
    chk("lat_overflow", lat, 19);
    chk("ovf_set", OVERFLOW, 1);
    step(1, 0, 0, 0, '0, r);
    step(1, 0, 0, 0, '0, r);
    chk("done_hold_stall", DONE, 1);
    step(0, 0, 0, 0, '0, r);
    chk("done_drop", DONE, 0);

    // START mid-stream must not clear the beat count: beat 16 still overflows.
    step(0, 1, 0, 0, '0, r);
    c0 = cyc;
    chk("ovf_clr", OVERFLOW, 0);
    repeat (15) step(0, 0, 1, 0, DW'($urandom), r);
    step(0, 1, 0, 0, '0, r);
    step(0, 0, 1, 0, DW'($urandom), r);
    chk("ovf_after_start_pulse", OVERFLOW, 1);
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (DONE === 1'b1) lat = cyc - c0;
      else step(0, 0, 0, 0, '0, r);
    end
    chk("lat_start_ignored", lat, 20);

    // Asynchronous reset while draining.
    step(0, 0, 0, 0, '0, r);
    step(0, 1, 0, 0, '0, r);
    step(0, 0, 1, 0, DW'($urandom), r);
    step(0, 0, 1, 1, DW'($urandom), r);
    step(0, 0, 0, 0, '0, r);
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("rst_mid_ready", IN_READY, 0);
    @(posedge CLK);
    #1;
    check_model();
    @(negedge CLK) RST = 1'b0;
    run_stream(2, 0, 0, 1, lat);
    chk("lat_after_rst", lat, 5);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 11) == 0, DW'($urandom), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
